// File: rtl/accel_job_sched_pkg.sv
// Shared state encoding, accelerator register map offsets and small helpers
// for the accelerator job sequencer.
package accel_job_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WR_OP  = 3'd1,
        ST_WR_GO  = 3'd2,
        ST_POLL   = 3'd3,
        ST_RD_RES = 3'd4,
        ST_RESP   = 3'd5
    } state_t;

    // Register offsets inside each accelerator window.
    localparam logic [31:0] OFS_OP   = 32'h0000_0000;
    localparam logic [31:0] OFS_GO   = 32'h0000_0004;
    localparam logic [31:0] OFS_STAT = 32'h0000_0008;
    localparam logic [31:0] OFS_RES  = 32'h0000_000C;

    localparam logic [31:0] GO_WORD  = 32'h0000_0001;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/accel_job_sched_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant from the request vector and
// the last-served pointer; the pointer updates when a job is returned.
module rr_arbiter2
    import accel_job_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    input  logic       update,
    input  logic       served,
    output logic [1:0] grant,
    output logic       grant_idx
);

    logic last_served;

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        grant_idx = 1'b0;
        case (req_valid)
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = ~last_served;
            default: grant_idx = 1'b0;
        endcase
        grant = (|req_valid) ? onehot2(grant_idx) : 2'b00;
    end

    // Resetting to 1 lets requester 0 win the first tie.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignment so all flops sample pre-edge values.
        if (rst) begin
            last_served <= 1'b1;
        end else if (update) begin
            last_served <= served;
        end
    end

endmodule

// File: rtl/accel_job_sched.sv
// Bus-master job sequencer sharing the factorial and FP accelerators between two
// requesters. Define ACCEL_TIMEOUT_EN to abort jobs that never report done.
module accel_job_sched
    import accel_job_sched_pkg::*;
#(
    parameter logic [31:0] FACT_BASE      = 32'h0000_0800,
    parameter logic [31:0] FP_BASE        = 32'h0000_0A00,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_acc,
    input  logic [31:0] req_op0,
    input  logic [31:0] req_op1,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic        bus_we,
    input  logic [31:0] bus_rdata,
    output logic        busy
);

    state_t      state;
    logic        grant_q;
    logic [31:0] op_q;
    logic [31:0] base_q;
    logic        err_q;

    logic [1:0]  grant;
    logic        grant_idx;
    logic [31:0] sel_op;
    logic [31:0] sel_base;

`ifdef ACCEL_TIMEOUT_EN
    logic [15:0] poll_cnt;
`endif

    rr_arbiter2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .update    (state == ST_RESP),
        .served    (grant_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = (state == ST_IDLE && !rst) ? grant : 2'b00;
    assign sel_op    = grant_idx ? req_op1 : req_op0;
    assign sel_base  = req_acc[grant_idx] ? FP_BASE : FACT_BASE;

    // Outputs are registered: each branch loads the values the next state drives.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            grant_q   <= 1'b0;
            op_q      <= '0;
            base_q    <= '0;
            err_q     <= 1'b0;
            rsp_valid <= 2'b00;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_we    <= 1'b0;
            busy      <= 1'b0;
`ifdef ACCEL_TIMEOUT_EN
            poll_cnt  <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        grant_q   <= grant_idx;
                        op_q      <= sel_op;
                        base_q    <= sel_base;
                        bus_addr  <= sel_base + OFS_OP;
                        bus_wdata <= sel_op;
                        bus_we    <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_WR_OP;
                    end
                end
                ST_WR_OP: begin
                    bus_addr  <= base_q + OFS_GO;
                    bus_wdata <= GO_WORD;
                    bus_we    <= 1'b1;
                    state     <= ST_WR_GO;
                end
                ST_WR_GO: begin
                    bus_addr  <= base_q + OFS_STAT;
                    bus_wdata <= '0;
                    bus_we    <= 1'b0;
`ifdef ACCEL_TIMEOUT_EN
                    poll_cnt  <= '0;
`endif
                    state     <= ST_POLL;
                end
                ST_POLL: begin
                    if (bus_rdata[0]) begin
                        err_q    <= bus_rdata[1];
                        bus_addr <= base_q + OFS_RES;
                        state    <= ST_RD_RES;
                    end
`ifdef ACCEL_TIMEOUT_EN
                    else if (poll_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                        rsp_valid <= onehot2(grant_q);
                        rsp_data  <= '0;
                        rsp_err   <= 1'b1;
                        bus_addr  <= '0;
                        state     <= ST_RESP;
                    end else begin
                        poll_cnt <= poll_cnt + 16'd1;
                    end
`endif
                end
                ST_RD_RES: begin
                    rsp_valid <= onehot2(grant_q);
                    rsp_data  <= bus_rdata;
                    rsp_err   <= err_q;
                    bus_addr  <= '0;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    rsp_valid <= 2'b00;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    rsp_valid <= 2'b00;
                    bus_addr  <= '0;
                    bus_wdata <= '0;
                    bus_we    <= 1'b0;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
